// File: rtl/seq_adder_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned NIB_W = 4;

endpackage

// File: rtl/nibble_serial_adder_ctrl_rca4.sv
// 4-bit ripple-carry adder slice shared across all nibbles of an operation.
module nibble_serial_adder_ctrl_rca4
  import seq_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum_c,
  output logic             cout_c
);

  logic [NIB_W:0] carry;

  // Ripple the carry through four full-adder cells.
  always_comb begin
    carry    = '0;
    sum_c    = '0;
    carry[0] = cin;
    for (int i = 0; i < int'(NIB_W); i++) begin
      sum_c[i]   = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout_c = carry[NIB_W];
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit adder: one shared 4-bit slice, LS nibble first,
// valid/ready on both sides. Optional subtract mode: SEQ_ADDER_SUB_EN.
module nibble_serial_adder_ctrl
  import seq_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned IDX_W = $clog2(NIB);

  state_t                      state;
  logic [IDX_W-1:0]            idx;
  logic                        carry_reg;
  logic [NIB-1:0][NIB_W-1:0]   a_reg;
  logic [NIB-1:0][NIB_W-1:0]   b_reg;
  logic [NIB-1:0][NIB_W-1:0]   sum_reg;
  logic [NIB_W-1:0]            a_nib;
  logic [NIB_W-1:0]            b_nib;
  logic [NIB_W-1:0]            s_nib;
  logic                        s_cout;
  logic                        last_nib;

`ifdef SEQ_ADDER_SUB_EN
  logic                        sub_reg;
`else
  logic                        unused_sub;
  assign unused_sub = sub;
`endif

  // Acceptance depends only on state; reset forces not-ready while asserted.
  assign in_ready = (state == IDLE) && !rst;
  assign sum      = sum_reg;
  assign last_nib = (idx == IDX_W'(NIB - 1));

  // Select the current operand nibbles; B is inverted for subtraction.
  always_comb begin
    a_nib = a_reg[idx];
    b_nib = b_reg[idx];
`ifdef SEQ_ADDER_SUB_EN
    if (sub_reg) begin
      b_nib = ~b_reg[idx];
    end
`endif
  end

  nibble_serial_adder_ctrl_rca4 u_rca4 (
    .a      (a_nib),
    .b      (b_nib),
    .cin    (carry_reg),
    .sum_c  (s_nib),
    .cout_c (s_cout)
  );

  // Sequencer: capture operands, walk the nibbles, hold result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
`ifdef SEQ_ADDER_SUB_EN
      sub_reg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            idx   <= '0;
            state <= RUN;
`ifdef SEQ_ADDER_SUB_EN
            sub_reg   <= sub;
            carry_reg <= sub ? 1'b1 : carry_in;
`else
            carry_reg <= carry_in;
`endif
          end
        end
        RUN: begin
          sum_reg[idx] <= s_nib;
          carry_reg    <= s_cout;
          idx          <= idx + IDX_W'(1);
          if (last_nib) begin
            carry_out <= s_cout;
            overflow  <= (a_nib[NIB_W-1] == b_nib[NIB_W-1]) &&
                         (s_nib[NIB_W-1] != a_nib[NIB_W-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl (WIDTH=16).
module tb_nibble_serial_adder_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int NIB = 4;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        carry_out;
  logic        overflow;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;
  bit   b2b      = 1'b0;
  bit   have_rise = 1'b0;
  int   last_rise = 0;
  bit   rnd_bp   = 1'b0;
  bit   pv       = 1'b0;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.acc = 0;
    return e;
  endfunction

  // Reference: plain integer arithmetic on whole operands.
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                 input logic cin, input logic sv);
    exp_t   e;
    longint ua, ub, us, sa, sbv, ss, c;
    bit     do_sub;
    do_sub = 1'b0;
`ifdef SEQ_ADDER_SUB_EN
    do_sub = sv;
`else
    if (sv) do_sub = 1'b0;
`endif
    ua = longint'(av); ub = longint'(bv);
    sa = longint'($signed(av)); sbv = longint'($signed(bv));
    c  = cin ? 64'sd1 : 64'sd0;
    if (do_sub) begin
      us     = ua - ub;
      e.cout = (ua >= ub);
      ss     = sa - sbv;
    end else begin
      us     = ua + ub + c;
      e.cout = (us >= 65536);
      ss     = sa + sbv + c;
    end
    e.sum = 16'(us);
    e.ovf = (ss > 32767) || (ss < -32768);
    e.acc = 0;
    return e;
  endfunction

  // Present operands until accepted; enqueue expected result when push is set.
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic cin,
                      input logic sv, input bit push, input exp_t e_in, output int acc);
    int   waited;
    bit   ok;
    exp_t e;
    waited = 0; ok = 1'b0; e = e_in;
    in_valid = 1'b1; a = av; b = bv; carry_in = cin; sub = sv;
    while (!ok && waited < 50) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        waited++;
      end
    end
    #1;
    in_valid = 1'b0;
    acc = cycle;
    chk("accepted", longint'(ok), 1);
    if (ok && push) begin
      e.acc = cycle;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  // Monitor: result content, hold stability, latency, spacing, in_ready.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      chk("in_ready_low_in_done", longint'(in_ready), 0);
      if (sb.size() == 0) begin
        chk("result_expected", sb.size(), 1);
      end else begin
        e = sb[0];
        if (!pv) begin
          chk("latency", cycle - e.acc, NIB);
          if (b2b && have_rise) chk("spacing", cycle - last_rise, 6);
          last_rise = cycle;
          have_rise = 1'b1;
        end
        chk("sum", sum, e.sum);
        chk("carry_out", longint'(carry_out), longint'(e.cout));
        chk("overflow", longint'(overflow), longint'(e.ovf));
        if (out_ready) void'(sb.pop_front());
      end
    end
    pv = !rst && out_valid;
  end

  initial begin
    int   acc;
    int   rc;
    int   n;
    logic [15:0] ra, rb;
    logic rcin, rsub;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_sum", sum, 0);
    chk("rst_carry_out", longint'(carry_out), 0);
    chk("rst_overflow", longint'(overflow), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", longint'(in_ready), 1);
    @(posedge clk); #1;

    // Basic adds, carry ripple across nibbles, unsigned carry and signed overflow
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h0100, 1'b0, 1'b0), acc);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b0), acc);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h8000, 1'b0, 1'b1), acc);
    drain();

    // Backpressure in DONE while new operands are offered
    out_ready = 1'b0;
    send(16'h1357, 16'h2468, 1'b0, 1'b0, 1'b1, mk(16'h37BF, 1'b0, 1'b0), acc);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("reached_done", longint'(out_valid), 1);
    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; carry_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    rc = cycle;
    send(16'h0101, 16'h0202, 1'b0, 1'b0, 1'b1, mk(16'h0303, 1'b0, 1'b0), acc);
    chk("reaccept_delay", acc - rc, 2);
    drain();

    // Reset after two nibbles of a run aborts it
    send(16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0, mk(16'h0, 1'b0, 1'b0), acc);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", longint'(out_valid), 0);
    chk("abort_sum", sum, 0);
    chk("abort_in_ready", longint'(in_ready), 1);
    @(posedge clk); #1;
    send(16'h1234, 16'h1111, 1'b1, 1'b0, 1'b1, mk(16'h2346, 1'b0, 1'b0), acc);
    drain();

    // Subtract request (honoured only when the option is built in)
`ifdef SEQ_ADDER_SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0), acc);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, mk(16'h7FFF, 1'b1, 1'b1), acc);
`else
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, mk(16'h000C, 1'b0, 1'b0), acc);
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, mk(16'h8002, 1'b0, 1'b0), acc);
`endif
    drain();

    // Back-to-back with out_ready high: results spaced by NIB+2 cycles
    have_rise = 1'b0;
    b2b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rcin = 1'($urandom_range(0, 1));
      send(ra, rb, rcin, 1'b0, 1'b1, model(ra, rb, rcin, 1'b0), acc);
    end
    drain();
    b2b = 1'b0;

    // Random operands with random consumer backpressure
    rnd_bp = 1'b1;
    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rcin = 1'($urandom_range(0, 1)); rsub = 1'($urandom_range(0, 1));
      send(ra, rb, rcin, rsub, 1'b1, model(ra, rb, rcin, rsub), acc);
    end
    rnd_bp = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
